// File: rtl/fifo_data_buffer.sv
// Slot-addressed data buffer: register storage with a per-slot unread bitmap,
// registered single-cycle read, occupancy count and sticky error flags.
module fifo_data_buffer #(
    parameter int A_W = 32,
    parameter int F_D = 16,
    parameter int D_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           we_n,
    input  logic           re_n,
    input  logic [A_W-1:0] wr_addr,
    input  logic [A_W-1:0] rd_addr,
    input  logic [D_W-1:0] wr_data,
    output logic [D_W-1:0] rd_data,
    output logic           rd_valid,
    output logic [A_W-1:0] occupancy,
    output logic           err_ovf,
    output logic           err_udf,
    output logic           err_addr,
    input  logic           err_clr
);

    localparam int             IDX_W = (F_D > 1) ? $clog2(F_D) : 1;
    localparam logic [A_W-1:0] DEPTH = A_W'(F_D);

    logic [D_W-1:0] mem [F_D];
    logic [F_D-1:0] slot_vld;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_ok;
    logic             rd_ok;
    logic             same_slot;
    logic             ovf_evt;
    logic             udf_evt;
    logic             addr_evt;

    // Strobes are single-cycle qualified events: no back-pressure, the buffer
    // accepts every in-range strobe in the cycle it is presented.
    always_comb begin
        wr_idx      = wr_addr[IDX_W-1:0];
        rd_idx      = rd_addr[IDX_W-1:0];
        wr_in_range = (wr_addr < DEPTH);
        rd_in_range = (rd_addr < DEPTH);
        wr_ok       = we_n && wr_in_range && !flush;
        rd_ok       = re_n && rd_in_range && !flush;
        same_slot   = rd_ok && (rd_idx == wr_idx);
        ovf_evt     = wr_ok && slot_vld[wr_idx] && !same_slot;
        udf_evt     = rd_ok && !slot_vld[rd_idx];
        addr_evt    = !flush && ((we_n && !wr_in_range) || (re_n && !rd_in_range));
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            occupancy <= '0;
            slot_vld  <= '0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
            err_addr  <= 1'b0;
        end else begin
            // Flush leaves the error flags alone; it also masks events above.
            err_ovf  <= (err_ovf  && !err_clr) || ovf_evt;
            err_udf  <= (err_udf  && !err_clr) || udf_evt;
            err_addr <= (err_addr && !err_clr) || addr_evt;
            if (flush) begin
                slot_vld  <= '0;
                occupancy <= '0;
                rd_valid  <= 1'b0;
            end else begin
                rd_valid <= rd_ok;
                if (rd_ok) begin
                    rd_data <= mem[rd_idx];
                end
                // Read clears first so a same-slot write leaves the slot valid.
                for (int i = 0; i < F_D; i++) begin
                    if (wr_ok && (wr_idx == IDX_W'(i))) begin
                        slot_vld[i] <= 1'b1;
                    end else if (rd_ok && (rd_idx == IDX_W'(i))) begin
                        slot_vld[i] <= 1'b0;
                    end
                end
                if (wr_ok && !rd_ok && (occupancy != DEPTH)) begin
                    occupancy <= occupancy + 1'b1;
                end else if (rd_ok && !wr_ok && (occupancy != '0)) begin
                    occupancy <= occupancy - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_data_buffer.sv
// Directed bench for fifo_data_buffer: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_fifo_data_buffer;

    localparam int A_W = 32;
    localparam int F_D = 16;
    localparam int D_W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           we_n;
    logic           re_n;
    logic [A_W-1:0] wr_addr;
    logic [A_W-1:0] rd_addr;
    logic [D_W-1:0] wr_data;
    logic [D_W-1:0] rd_data;
    logic           rd_valid;
    logic [A_W-1:0] occupancy;
    logic           err_ovf;
    logic           err_udf;
    logic           err_addr;
    logic           err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_data_buffer #(.A_W(A_W), .F_D(F_D), .D_W(D_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .we_n      (we_n),
        .re_n      (re_n),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .occupancy (occupancy),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; we_n = 0; re_n = 0; err_clr = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic ovf, input logic udf, input logic adr);
        chk({tag, " err_ovf"},  64'(err_ovf),  64'(ovf));
        chk({tag, " err_udf"},  64'(err_udf),  64'(udf));
        chk({tag, " err_addr"}, 64'(err_addr), 64'(adr));
    endtask

    task automatic wr(input int a, input logic [D_W-1:0] d);
        idle(); we_n = 1; wr_addr = A_W'(a); wr_data = d;
        cyc();
    endtask

    task automatic rd(input int a);
        idle(); re_n = 1; rd_addr = A_W'(a);
        cyc();
    endtask

    initial begin
        // Reset
        idle(); rst = 1;
        cyc(); cyc();
        chk("reset rd_data", 64'(rd_data), 64'h0);
        chk("reset rd_valid", 64'(rd_valid), 64'h0);
        chk("reset occupancy", 64'(occupancy), 64'd0);
        chk_err("reset", 0, 0, 0);

        // Fill all slots then drain in order
        for (int i = 0; i < F_D; i++) begin
            wr(i, D_W'(32'hA0 + i));
            chk($sformatf("fill occ %0d", i), 64'(occupancy), 64'(i + 1));
        end
        chk_err("fill", 0, 0, 0);
        for (int i = 0; i < F_D; i++) begin
            rd(i);
            chk($sformatf("drain data %0d", i), 64'(rd_data), 64'(32'hA0 + i));
            chk($sformatf("drain valid %0d", i), 64'(rd_valid), 64'h1);
            chk($sformatf("drain occ %0d", i), 64'(occupancy), 64'(F_D - 1 - i));
        end
        idle(); cyc();
        chk("idle rd_valid", 64'(rd_valid), 64'h0);
        chk("idle rd_data hold", 64'(rd_data), 64'hAF);
        chk_err("drain", 0, 0, 0);

        // Refill with slot 3 = 0x33, then overwrite slot 0 at full
        for (int i = 0; i < F_D; i++) wr(i, (i == 3) ? 32'h33 : D_W'(32'hA0 + i));
        chk("refill occ", 64'(occupancy), 64'd16);
        wr(0, 32'hA0);
        chk("full overwrite occ sat", 64'(occupancy), 64'd16);
        chk("full overwrite err_ovf", 64'(err_ovf), 64'h1);
        idle(); err_clr = 1; cyc();
        chk_err("clr ovf", 0, 0, 0);

        // Same-slot read and write: read-before-write
        idle(); we_n = 1; re_n = 1; wr_addr = 3; rd_addr = 3; wr_data = 32'h55;
        cyc();
        chk("rw same rd_data", 64'(rd_data), 64'h33);
        chk("rw same rd_valid", 64'(rd_valid), 64'h1);
        chk("rw same occ", 64'(occupancy), 64'd16);
        chk_err("rw same", 0, 0, 0);
        rd(3);
        chk("slot3 new data", 64'(rd_data), 64'h55);
        chk("slot3 still valid", 64'(err_udf), 64'h0);
        chk("slot3 read occ", 64'(occupancy), 64'd15);
        idle(); flush = 1; cyc();
        chk("flush occ", 64'(occupancy), 64'd0);
        chk("flush rd_valid", 64'(rd_valid), 64'h0);
        chk("flush rd_data hold", 64'(rd_data), 64'h55);

        // Underflow read, then clear racing a new event, then plain clear
        rd(5);
        chk("udf rd_valid", 64'(rd_valid), 64'h1);
        chk("udf rd_data stale", 64'(rd_data), 64'hA5);
        chk("udf occ sat", 64'(occupancy), 64'd0);
        chk_err("udf", 0, 1, 0);
        idle(); re_n = 1; rd_addr = 6; err_clr = 1; cyc();
        chk("clr vs event err_udf", 64'(err_udf), 64'h1);
        chk("clr vs event rd_data", 64'(rd_data), 64'hA6);
        idle(); err_clr = 1; cyc();
        chk_err("clr udf", 0, 0, 0);
        chk("clr rd_valid", 64'(rd_valid), 64'h0);

        // Out-of-range accesses
        idle(); we_n = 1; wr_addr = 16; wr_data = 32'hDEAD; re_n = 1; rd_addr = 20;
        cyc();
        chk("oor occ", 64'(occupancy), 64'd0);
        chk("oor rd_valid", 64'(rd_valid), 64'h0);
        chk("oor rd_data hold", 64'(rd_data), 64'hA6);
        chk_err("oor", 0, 0, 1);
        idle(); err_clr = 1; cyc();
        chk_err("clr addr", 0, 0, 0);

        // Occupancy 7 then flush with concurrent write and read
        for (int i = 0; i < 8; i++) wr(i, D_W'(32'h10 + i));
        rd(0);
        chk("pre-flush rd_data", 64'(rd_data), 64'h10);
        chk("pre-flush occ", 64'(occupancy), 64'd7);
        wr(16, 32'hBEEF);
        chk("pre-flush err_addr", 64'(err_addr), 64'h1);
        idle(); flush = 1; we_n = 1; wr_addr = 8; wr_data = 32'h99; re_n = 1; rd_addr = 1;
        cyc();
        chk("flush7 occ", 64'(occupancy), 64'd0);
        chk("flush7 rd_valid", 64'(rd_valid), 64'h0);
        chk("flush7 rd_data hold", 64'(rd_data), 64'h10);
        chk_err("flush7", 0, 0, 1);
        rd(8);
        chk("flush suppressed write data", 64'(rd_data), 64'hA8);
        chk("flush cleared slot8", 64'(err_udf), 64'h1);
        idle(); err_clr = 1; cyc();
        rd(1);
        chk("flush cleared slot1", 64'(err_udf), 64'h1);
        chk("post-flush occ", 64'(occupancy), 64'd0);
        idle(); err_clr = 1; cyc();

        // Reset during a read
        wr(2, 32'h77);
        chk("pre-rst occ", 64'(occupancy), 64'd1);
        idle(); re_n = 1; rd_addr = 2; rst = 1; cyc();
        chk("rst rd_valid", 64'(rd_valid), 64'h0);
        chk("rst rd_data", 64'(rd_data), 64'h0);
        chk("rst occ", 64'(occupancy), 64'd0);
        chk_err("rst", 0, 0, 0);
        idle(); cyc();
        chk("post-rst rd_valid", 64'(rd_valid), 64'h0);
        rd(2);
        chk("post-rst mem kept", 64'(rd_data), 64'h77);
        chk("post-rst slot cleared", 64'(err_udf), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_data_buffer.md
FIFO_DATA_BUFFER -- requirements
Module: fifo_data_buffer

Interface
REQ-001 Parameter A_W, default 32 (`A_W, param_define.v), SHALL be the address and occupancy width.
REQ-002 Parameter F_D, default 16 (`F_D), SHALL be the buffer depth in entries.
REQ-003 Parameter D_W, default 32 (`D_W), SHALL be the data word width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 flush  input  1  SHALL be the synchronous clear of buffer state, same priority class as rst.
REQ-007 we_n  input  1  SHALL be the qualified write strobe from the address-update stage.
REQ-008 re_n  input  1  SHALL be the qualified read strobe from the address-update stage.
REQ-009 wr_addr  input  A_W  SHALL be the write slot index.
REQ-010 rd_addr  input  A_W  SHALL be the read slot index.
REQ-011 wr_data  input  D_W  SHALL be the write data, sampled when we_n=1.
REQ-012 rd_data  output  D_W  SHALL be the registered read data.
REQ-013 rd_valid  output  1  SHALL flag rd_data as new for exactly one cycle.
REQ-014 occupancy  output  A_W  SHALL be the count of slots holding unread data.
REQ-015 err_ovf  output  1  SHALL be sticky: write into an unread slot.
REQ-016 err_udf  output  1  SHALL be sticky: read of an empty slot.
REQ-017 err_addr  output  1  SHALL be sticky: access with address >= F_D.
REQ-018 err_clr  input  1  SHALL clear all three sticky error flags.

Function
REQ-019 Storage SHALL be F_D x D_W registers, not reset; a per-slot valid bitmap slot_vld[F_D] SHALL track unread data.
REQ-020 Write: we_n=1 and wr_addr<F_D SHALL store wr_data at mem[wr_addr] and set slot_vld[wr_addr] at the next edge.
REQ-021 Read: re_n=1 and rd_addr<F_D SHALL load rd_data<=mem[rd_addr], clear slot_vld[rd_addr], and assert rd_valid the next cycle (1-cycle latency).
REQ-022 rd_valid SHALL be 0 in any cycle following a cycle without an accepted read; rd_data SHALL hold its last value.
REQ-023 Simultaneous read and write to the same slot SHALL return the pre-write content (read-before-write); slot_vld SHALL end at 1.
REQ-024 occupancy SHALL increment on accepted write only, decrement on accepted read only, and hold on both or neither; it SHALL never wrap (saturate at 0 and F_D).
REQ-025 err_ovf SHALL set when an accepted write hits a slot with slot_vld=1 not being read in the same cycle; the write SHALL still complete.
REQ-026 err_udf SHALL set when an accepted read hits a slot with slot_vld=0; rd_valid SHALL still assert with the stale content.
REQ-027 Any we_n or re_n with its address >= F_D SHALL be ignored (no storage, bitmap, or occupancy change) and SHALL set err_addr.
REQ-028 err_clr SHALL clear errors at the next edge; a new error event in the same cycle SHALL win (flag stays 1).
REQ-029 flush=1 SHALL clear slot_vld, occupancy, and rd_valid, SHALL suppress same-cycle reads and writes, and SHALL NOT change rd_data, mem, or error flags.

Reset
REQ-030 rst=1 SHALL force rd_data=0, rd_valid=0, occupancy=0, slot_vld=0, err_ovf=err_udf=err_addr=0 at the next edge, overriding all other inputs.
REQ-031 rst asserted mid-operation SHALL discard any in-flight read; rd_valid SHALL be 0 the cycle after reset.

Verification
REQ-032 Write 0xA0..0xAF to addrs 0..15, then read 0..15 -> rd_data 0xA0..0xAF one cycle after each re_n, occupancy 16 then 0, no errors.
REQ-033 Full buffer, we_n=re_n=1, wr_addr=rd_addr=3, wr_data=0x55, mem[3]=0x33 -> rd_data=0x33, slot 3 valid, occupancy stays 16, err_ovf=0.
REQ-034 Read addr 5 on an empty buffer -> rd_valid=1, err_udf=1, occupancy 0; then err_clr -> err_udf=0.
REQ-035 we_n=1 with wr_addr=16 -> no occupancy change, err_addr=1.
REQ-036 Occupancy 7, flush with we_n=1 -> occupancy 0, slot_vld all 0, rd_valid 0, errors unchanged.
REQ-037 rst during re_n=1 -> next cycle rd_valid=0, rd_data=0, occupancy=0.
